// File: rtl/maxpool_pkg.sv
// Shared defaults, POOL limits and the sample compare used by stream_maxpool.
package maxpool_pkg;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;
    localparam int DEF_CHANNELS   = 1;
    localparam int DEF_POOL       = 2;
    localparam int DEF_SIGNED_CMP = 0;
    localparam int POOL_MIN       = 2;
    localparam int POOL_MAX       = 4;
    localparam int MAX_W          = 64;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Callers pass zero-extended samples of width w. Flipping bit w-1 maps
    // two's-complement order onto unsigned order, so one magnitude compare
    // serves both modes.
    function automatic logic sample_gt(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int               w,
                                       input logic             signed_cmp);
        logic [MAX_W-1:0] bias;
        bias = signed_cmp ? (MAX_W'(1) << (w - 1)) : '0;
        return (a ^ bias) > (b ^ bias);
    endfunction
endpackage

// File: rtl/pool_rowbuf.sv
// Partial-max line buffer: one combinational read port, one synchronous write port.
module pool_rowbuf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 14,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end
endmodule

// File: rtl/stream_maxpool.sv
// Streaming POOLxPOOL max-pool over a raster frame with interleaved channels,
// one partial max per (output column, channel) held in a line buffer.
module stream_maxpool
    import maxpool_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int POOL       = DEF_POOL,
    parameter int SIGNED_CMP = DEF_SIGNED_CMP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int OW    = IMG_W / POOL;
    localparam int OH    = IMG_H / POOL;
    localparam int DEPTH = OW * CHANNELS;
    localparam int CW    = cnt_w(CHANNELS);
    localparam int XW    = cnt_w(IMG_W);
    localparam int YW    = cnt_w(IMG_H);
    localparam int PW    = cnt_w(POOL);
    localparam int OXW   = cnt_w(OW + 1);
    localparam int OYW   = cnt_w(OH + 1);
    localparam int AW    = cnt_w(DEPTH);

    if (POOL < POOL_MIN || POOL > POOL_MAX) begin : g_pool_range
        $error("stream_maxpool: POOL out of range");
    end

    logic [CW-1:0]     ch;
    logic [XW-1:0]     col;
    logic [YW-1:0]     row;
    // Window phase and output coordinates track col/row so no divider is needed.
    logic [PW-1:0]     pc, pr;
    logic [OXW-1:0]    ocol;
    logic [OYW-1:0]    orow;
    logic              xfer, in_win, first_el, last_el;
    logic              ch_wrap, col_wrap, frame_end, take_new, emit;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] stored, merged;

    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;
    assign in_win    = (ocol < OXW'(OW)) && (orow < OYW'(OH));
    assign first_el  = (pc == '0) && (pr == '0);
    assign last_el   = (pc == PW'(POOL - 1)) && (pr == PW'(POOL - 1));
    assign ch_wrap   = ch == CW'(CHANNELS - 1);
    assign col_wrap  = col == XW'(IMG_W - 1);
    assign frame_end = ch_wrap && col_wrap && (row == YW'(IMG_H - 1));
    assign idx       = AW'(int'(ocol) * CHANNELS + int'(ch));
    assign take_new  = first_el ||
                       sample_gt(MAX_W'(in_data), MAX_W'(stored), DATA_W, SIGNED_CMP != 0);
    assign merged    = take_new ? in_data : stored;
    assign emit      = xfer && in_win && last_el;

    pool_rowbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_rowbuf (
        .clk     (clk),
        .we      (xfer && in_win),
        .wr_addr (idx),
        .wr_data (merged),
        .rd_addr (idx),
        .rd_data (stored)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0; col <= '0; row <= '0;
            pc <= '0; pr <= '0; ocol <= '0; orow <= '0;
        end else if (xfer) begin
            // An early in_last resyncs to frame start.
            if (in_last || frame_end) begin
                ch <= '0; col <= '0; row <= '0;
                pc <= '0; pr <= '0; ocol <= '0; orow <= '0;
            end else if (!ch_wrap) begin
                ch <= ch + 1'b1;
            end else begin
                ch <= '0;
                if (!col_wrap) begin
                    col <= col + 1'b1;
                    if (pc == PW'(POOL - 1)) begin
                        pc   <= '0;
                        ocol <= ocol + 1'b1;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end else begin
                    col  <= '0;
                    pc   <= '0;
                    ocol <= '0;
                    row  <= row + 1'b1;
                    if (pr == PW'(POOL - 1)) begin
                        pr   <= '0;
                        orow <= orow + 1'b1;
                    end else begin
                        pr <= pr + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= merged;
            out_last  <= (ocol == OXW'(OW - 1)) && (orow == OYW'(OH - 1)) && ch_wrap;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_maxpool.sv
// Directed scoreboard bench for stream_maxpool across several parameter sets.
module tb_stream_maxpool;
    localparam int ND = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       din;
    logic              dlast;
    logic [ND-1:0]     ivld, ordy, ordy_eff, ir, ov, ol;
    logic [15:0]       od [ND];
    logic              stall_en, rnd_rdy;

    typedef struct {
        int          dut;
        logic [15:0] d;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign ordy_eff = {ordy[ND-1:1], stall_en ? rnd_rdy : ordy[0]};

    // 0: 4x4 unsigned, 1: 4x2 signed, 2: 4x2 unsigned, 3: 5x5, 4: 2x2 two channels
    stream_maxpool #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CHANNELS(1), .POOL(2), .SIGNED_CMP(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(ivld[0]), .in_ready(ir[0]), .in_last(dlast),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy_eff[0]), .out_last(ol[0]));
    stream_maxpool #(.DATA_W(16), .IMG_W(4), .IMG_H(2), .CHANNELS(1), .POOL(2), .SIGNED_CMP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(ivld[1]), .in_ready(ir[1]), .in_last(dlast),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy_eff[1]), .out_last(ol[1]));
    stream_maxpool #(.DATA_W(16), .IMG_W(4), .IMG_H(2), .CHANNELS(1), .POOL(2), .SIGNED_CMP(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(ivld[2]), .in_ready(ir[2]), .in_last(dlast),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy_eff[2]), .out_last(ol[2]));
    stream_maxpool #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .CHANNELS(1), .POOL(2), .SIGNED_CMP(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(ivld[3]), .in_ready(ir[3]), .in_last(dlast),
        .out_data(od[3]), .out_valid(ov[3]), .out_ready(ordy_eff[3]), .out_last(ol[3]));
    stream_maxpool #(.DATA_W(16), .IMG_W(2), .IMG_H(2), .CHANNELS(2), .POOL(2), .SIGNED_CMP(0)) u_e (
        .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(ivld[4]), .in_ready(ir[4]), .in_last(dlast),
        .out_data(od[4]), .out_valid(ov[4]), .out_ready(ordy_eff[4]), .out_last(ol[4]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input int s, input logic [15:0] d, input logic l);
        exp_t e;
        e.dut = s; e.d = d; e.last = l;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send(input int s, input logic [15:0] d, input logic last);
        int n;
        n = 0;
        if (stall_en && $urandom_range(2) == 0) begin
            @(posedge clk); #1;
        end
        din = d; dlast = last; ivld[s] = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ir[s]) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'(ir[s]), 32'h1);
                break;
            end
        end
        @(posedge clk); #1;
        ivld[s] = 1'b0; dlast = 1'b0;
    endtask

    task automatic send_seq(input int s, input int start, input int n, input int dir, input bit last);
        for (int i = 0; i < n; i++)
            send(s, 16'(start + dir * i), last && (i == n - 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(2) != 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < ND; i++) begin
                if (ov[i] && ordy_eff[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_dut", 32'(i), 32'hffff);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_dut", 32'(i), 32'(e.dut));
                        chk("out_data", 32'(od[i]), 32'(e.d));
                        chk("out_last", 32'(ol[i]), 32'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sv [8];
        logic [15:0] ev [8];
        sv = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFF8, 16'h8000, 16'h8000};
        ev = '{16'd1, 16'd9, 16'd4, 16'd2, 16'd3, 16'd3, 16'd0, 16'd7};
        ivld = '0; ordy = '1; din = '0; dlast = 1'b0; stall_en = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(ov), 32'h0);
        chk("rst_out_last", 32'(ol), 32'h0);
        chk("rst_out_data", 32'(od[0]), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(ir), 32'h1f);

        // 4x4 ascending
        expect_out(0, 16'd5, 0); expect_out(0, 16'd7, 0);
        expect_out(0, 16'd13, 0); expect_out(0, 16'd15, 1);
        send_seq(0, 0, 16, 1, 1);
        wait_drain();

        // Signed vs unsigned compare on the same stream
        expect_out(1, 16'h0001, 0); expect_out(1, 16'h7FFF, 1);
        for (int i = 0; i < 8; i++) send(1, sv[i], i == 7);
        wait_drain();
        expect_out(2, 16'hFFFF, 0); expect_out(2, 16'h8000, 1);
        for (int i = 0; i < 8; i++) send(2, sv[i], i == 7);
        wait_drain();

        // 5x5 with trailing column/row discarded
        expect_out(3, 16'd6, 0); expect_out(3, 16'd8, 0);
        expect_out(3, 16'd16, 0); expect_out(3, 16'd18, 1);
        send_seq(3, 0, 25, 1, 1);
        wait_drain();

        // Two interleaved channels
        expect_out(4, 16'd4, 0); expect_out(4, 16'd9, 1);
        for (int i = 0; i < 8; i++) send(4, ev[i], i == 7);
        wait_drain();

        // Output backpressure holds result and blocks input
        ordy[0] = 1'b0;
        expect_out(0, 16'd5, 0); expect_out(0, 16'd7, 0);
        expect_out(0, 16'd13, 0); expect_out(0, 16'd15, 1);
        send_seq(0, 0, 6, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(ov[0]), 32'h1);
            chk("stall_in_ready", 32'(ir[0]), 32'h0);
            chk("stall_out_data", 32'(od[0]), 32'd5);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        send_seq(0, 6, 10, 1, 1);
        wait_drain();

        // Random stalls on both sides
        stall_en = 1'b1;
        expect_out(0, 16'd15, 0); expect_out(0, 16'd13, 0);
        expect_out(0, 16'd7, 0); expect_out(0, 16'd5, 1);
        send_seq(0, 15, 16, -1, 1);
        expect_out(0, 16'd5, 0); expect_out(0, 16'd7, 0);
        expect_out(0, 16'd13, 0); expect_out(0, 16'd15, 1);
        send_seq(0, 0, 16, 1, 1);
        wait_drain();
        stall_en = 1'b0;

        // Reset mid-frame after 7 samples, then a clean frame
        expect_out(0, 16'd5, 0);
        send_seq(0, 0, 7, 1, 0);
        wait_drain();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(ov[0]), 32'h0);
        chk("midrst_out_data", 32'(od[0]), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_out(0, 16'd5, 0); expect_out(0, 16'd7, 0);
        expect_out(0, 16'd13, 0); expect_out(0, 16'd15, 1);
        send_seq(0, 0, 16, 1, 1);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_maxpool.md
STREAM_MAXPOOL -- requirements
Module: stream_maxpool

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning pixel/channel sample width in bits.
REQ-002 SHALL have parameter IMG_W, default 28, meaning input frame width in pixels.
REQ-003 SHALL have parameter IMG_H, default 28, meaning input frame height in pixels.
REQ-004 SHALL have parameter CHANNELS, default 1, meaning channel samples per pixel, interleaved ch0..chN-1.
REQ-005 SHALL have parameter POOL, default 2, meaning square window size and stride (2..4).
REQ-006 SHALL have parameter SIGNED_CMP, default 0, meaning 1 = two's-complement compare, 0 = unsigned compare.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port in_data, input, DATA_W, input sample.
REQ-010 SHALL have port in_valid, input, 1, in_data valid.
REQ-011 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-012 SHALL have port in_last, input, 1, marks final sample of a frame.
REQ-013 SHALL have port out_data, output, DATA_W, pooled sample.
REQ-014 SHALL have port out_valid, output, 1, out_data valid.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts.
REQ-016 SHALL have port out_last, output, 1, marks final pooled sample of a frame.

Function
REQ-017 SHALL consume samples in raster order, channel fastest, then column, then row; a beat transfers when in_valid && in_ready.
REQ-018 SHALL track ch, col, row counters advancing only on input transfers; ch wraps at CHANNELS, col at IMG_W, row at IMG_H, all returning to 0 after the last sample of a frame.
REQ-019 SHALL hold a partial-max buffer of (IMG_W/POOL)*CHANNELS entries, index (col/POOL)*CHANNELS+ch.
REQ-020 SHALL write the sample directly on the first window element (row%POOL==0 && col%POOL==0); otherwise write max(stored, sample).
REQ-021 SHALL, on the last window element (row%POOL==POOL-1 && col%POOL==POOL-1), load max(stored, sample) into the out_data register and set out_valid on the next edge (latency 1 cycle).
REQ-022 SHALL ignore (accept and discard) samples in trailing columns col >= (IMG_W/POOL)*POOL and trailing rows row >= (IMG_H/POOL)*POOL.
REQ-023 SHALL compare per SIGNED_CMP; ties keep the stored value; output width equals DATA_W, no saturation or rounding.
REQ-024 SHALL drive in_ready = !out_valid || out_ready (single-entry output skid, no combinational in_valid->out_valid path).
REQ-025 SHALL hold out_data/out_valid/out_last stable while out_valid && !out_ready; clear out_valid on transfer unless a new result loads the same cycle.
REQ-026 SHALL assert out_last with the pooled sample of last output row, last output column, channel CHANNELS-1.
REQ-027 SHALL, when in_last arrives before counters reach the frame end, reset counters to 0 after that beat (frame resync) without emitting extra outputs; in_last at the expected position is a no-op.
REQ-028 SHALL emit (IMG_W/POOL)*(IMG_H/POOL)*CHANNELS outputs per complete frame.

Reset
REQ-029 SHALL on rst_n low immediately clear out_valid, out_last, out_data, ch, col, row to 0; in_ready reads 1 while in reset-released idle.
REQ-030 SHALL not require buffer contents cleared; a reset mid-frame restarts at the next sample as frame position (0,0,0).

Structure
REQ-031 SHALL place parameter defaults, POOL bounds, and the compare function in shared package maxpool_pkg.
REQ-032 SHALL implement the partial-max buffer as sub-module pool_rowbuf (combinational read, synchronous write, one port each).

Verification
REQ-033 SHALL test 4x4, CHANNELS=1, POOL=2, inputs 0..15 -> outputs 5,7,13,15; out_last only on 15.
REQ-034 SHALL test SIGNED_CMP=1, window {-1,-3,1,-8} (0xFFFF,0xFFFD,0x0001,0xFFF8) -> 0x0001; SIGNED_CMP=0 same window -> 0xFFFF.
REQ-035 SHALL test 5x5, POOL=2, inputs 0..24 -> outputs 6,8,16,18 only; column 4/row 4 discarded.
REQ-036 SHALL test CHANNELS=2, 2x2 pixels (a,b)=(1,9),(4,2),(3,3),(0,7) -> outputs 4 then 9.
REQ-037 SHALL test out_ready held low 5 cycles with out_valid set -> in_ready low, out_data stable, no sample lost; 33% random stalls on both sides match model.
REQ-038 SHALL test rst_n low mid-frame after 7 samples of 4x4 frame, then full frame 0..15 -> outputs exactly 5,7,13,15.
